data_router_buf: RTL

//  Synthesizable, parametrised line-buffer router that feeds the PE array.

---
 rtl/data_router_buf_if.sv | 55 +++++
 rtl/data_router_buf.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_router_buf_if.sv
// Bundles the producer write port, the PE-side command port and the window
// outputs of data_router_buf.
//   master : producer/consumer side (drives write rows, commands, blk_done)
//   slave  : router side (drives ready flags, window data and status)
// Signals:
//   wr_valid/wr_ready/wr_bank/wr_row/wr_data    row load handshake
//   cmd_valid/cmd_ready/cmd_mode/cmd_bank/
//   cmd_row/cmd_col                             read command handshake
//   blk_done                                    consumer block-finished pulse
//   data_o/out_valid                            window and update pulse
//   blk_rdy/blkend/err                          block status and sticky error
interface data_router_buf_if #(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int BUFW = 32,
  parameter int BUFH = 3
);
  localparam int BW = (POY  > 1) ? $clog2(POY)  : 1;
  localparam int RW = (BUFH > 1) ? $clog2(BUFH) : 1;
  localparam int CW = (BUFW > 1) ? $clog2(BUFW) : 1;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [BW-1:0]           wr_bank;
  logic [RW-1:0]           wr_row;
  logic [BUFW*DW-1:0]      wr_data;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_mode;
  logic [BW-1:0]           cmd_bank;
  logic [RW-1:0]           cmd_row;
  logic [CW-1:0]           cmd_col;

  logic                    blk_done;
  logic [POY*BUFW*DW-1:0]  data_o;
  logic                    out_valid;
  logic                    blk_rdy;
  logic                    blkend;
  logic                    err;

  modport master (
    output wr_valid, wr_bank, wr_row, wr_data,
    output cmd_valid, cmd_mode, cmd_bank, cmd_row, cmd_col,
    output blk_done,
    input  wr_ready, cmd_ready, data_o, out_valid, blk_rdy, blkend, err
  );

  modport slave (
    input  wr_valid, wr_bank, wr_row, wr_data,
    input  cmd_valid, cmd_mode, cmd_bank, cmd_row, cmd_col,
    input  blk_done,
    output wr_ready, cmd_ready, data_o, out_valid, blk_rdy, blkend, err
  );
endinterface

// File: rtl/data_router_buf.sv
// Line-buffer router feeding the PE array. Holds POY banks of BUFH rows of
// BUFW words. In FILL the producer loads whole rows; once every row of every
// bank is valid the block moves to READY, where PE-side commands build the
// output window:
//   RR (00) : every bank's window <= its row
//   BR (01) : one bank's window <= its row, others hold
//   RP (10) : one word column of every bank <= row word, others hold
//   SH (11) : window shifts toward word 0 by STRIDE, upper words refilled
//             from row words col..col+STRIDE-1 (wrapping modulo BUFW)
// blk_done in READY retires the block: blkend pulses, rows are invalidated.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : data_router_buf_if.slave (write port, command port, window,
//            blk_rdy/blkend/err status)
module data_router_buf #(
  parameter int DW     = 32,
  parameter int POY    = 3,
  parameter int BUFW   = 32,
  parameter int BUFH   = 3,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  data_router_buf_if.slave  bus
);
  localparam int BW = (POY  > 1) ? $clog2(POY)  : 1;
  localparam int RW = (BUFH > 1) ? $clog2(BUFH) : 1;
  localparam int CW = (BUFW > 1) ? $clog2(BUFW) : 1;
  localparam int NROWS = POY * BUFH;
  localparam int IW = (NROWS > 1) ? $clog2(NROWS) : 1;

  localparam logic [1:0] MODE_RR = 2'b00;
  localparam logic [1:0] MODE_BR = 2'b01;
  localparam logic [1:0] MODE_RP = 2'b10;
  localparam logic [1:0] MODE_SH = 2'b11;

  typedef enum logic [0:0] {FILL, READY} state_t;

  state_t             state, state_nxt;
  logic [NROWS-1:0]   row_vld, row_vld_nxt;
  logic [DW-1:0]      mem [POY][BUFH][BUFW];
  logic [DW-1:0]      win [POY][BUFW];
  logic [DW-1:0]      win_nxt [POY][BUFW];
  logic [CW:0]        sh_src;
  logic               out_valid_r, blkend_r, err_r;

  logic               wr_fire, wr_bad, wr_legal;
  logic               cmd_fire, cmd_bad, cmd_legal;
  logic [IW-1:0]      wr_idx;

  assign bus.wr_ready  = (state == FILL);
  assign bus.cmd_ready = (state == READY);
  assign bus.blk_rdy   = (state == READY);
  assign bus.out_valid = out_valid_r;
  assign bus.blkend    = blkend_r;
  assign bus.err       = err_r;

  assign wr_fire  = bus.wr_valid & bus.wr_ready;
  assign wr_bad   = (32'(bus.wr_bank) >= POY) || (32'(bus.wr_row) >= BUFH);
  assign wr_legal = wr_fire & ~wr_bad;
  assign wr_idx   = IW'(32'(bus.wr_bank) * BUFH + 32'(bus.wr_row));

  // All index fields are checked regardless of mode; a bad field consumes
  // the command without touching the window.
  assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
  assign cmd_bad   = (32'(bus.cmd_bank) >= POY) || (32'(bus.cmd_row) >= BUFH) ||
                     (32'(bus.cmd_col) >= BUFW);
  assign cmd_legal = cmd_fire & ~cmd_bad;

  // Row storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_legal) begin
      for (int w = 0; w < BUFW; w++) begin
        mem[bus.wr_bank][bus.wr_row][w] <= bus.wr_data[w*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      row_vld     <= '0;
      out_valid_r <= 1'b0;
      blkend_r    <= 1'b0;
      err_r       <= 1'b0;
      win         <= '{default: '0};
    end else begin
      state       <= state_nxt;
      row_vld     <= row_vld_nxt;
      out_valid_r <= cmd_legal;
      blkend_r    <= (state == READY) & bus.blk_done;
      err_r       <= err_r | (wr_fire & wr_bad) | (cmd_fire & cmd_bad);
      win         <= win_nxt;
    end
  end

  // The block becomes READY on the same edge that stores its last missing
  // row, so blk_rdy rises the cycle after that write handshake.
  always_comb begin
    state_nxt   = state;
    row_vld_nxt = row_vld;
    case (state)
      FILL: begin
        if (wr_legal) row_vld_nxt[wr_idx] = 1'b1;
        if (&row_vld_nxt) state_nxt = READY;
      end
      READY: begin
        if (bus.blk_done) begin
          state_nxt   = FILL;
          row_vld_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    win_nxt = win;
    sh_src  = '0;
    if (cmd_legal) begin
      case (bus.cmd_mode)
        MODE_RR: begin
          for (int b = 0; b < POY; b++)
            for (int w = 0; w < BUFW; w++)
              win_nxt[b][w] = mem[b][bus.cmd_row][w];
        end
        MODE_BR: begin
          for (int w = 0; w < BUFW; w++)
            win_nxt[bus.cmd_bank][w] = mem[bus.cmd_bank][bus.cmd_row][w];
        end
        MODE_RP: begin
          for (int b = 0; b < POY; b++)
            win_nxt[b][bus.cmd_col] = mem[b][bus.cmd_row][bus.cmd_col];
        end
        MODE_SH: begin
          for (int b = 0; b < POY; b++) begin
            for (int w = 0; w < BUFW - STRIDE; w++)
              win_nxt[b][w] = win[b][w + STRIDE];
            // col < BUFW and k < BUFW, so a single subtract wraps the index.
            for (int k = 0; k < STRIDE; k++) begin
              sh_src = {1'b0, bus.cmd_col} + (CW+1)'(k);
              if (sh_src >= (CW+1)'(BUFW)) sh_src = sh_src - (CW+1)'(BUFW);
              win_nxt[b][BUFW - STRIDE + k] = mem[b][bus.cmd_row][sh_src[CW-1:0]];
            end
          end
        end
        default: win_nxt = win;
      endcase
    end
  end

  for (genvar gb = 0; gb < POY; gb++) begin : g_bank
    for (genvar gw = 0; gw < BUFW; gw++) begin : g_word
      assign bus.data_o[(gb*BUFW + gw)*DW +: DW] = win[gb][gw];
    end
  end

endmodule
